// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI mode-0 responder.
// State encoding, line idle levels and the default idle word.
package spi_slave_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  localparam logic SCLK_IDLE = CPOL;
  localparam logic CS_N_IDLE = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

  localparam int unsigned MAX_N = 64;
  localparam logic [MAX_N-1:0] IDLE_WORD_DEFAULT = '1;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with an extra flop for edge detection.
// Flops reset to the idle level of the line they watch.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_c,
  input  logic reset_r,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // Resynchronise the pin and keep one older sample
  always_ff @(posedge clk_c or posedge reset_r) begin
    if (reset_r) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/spi_slave_shiftreg.sv
// SPI mode-0 responder, MSB first, oversampled in the clk_c domain.
// Received words pulse out; transmit words come from a one-entry buffer.
module spi_slave_shiftreg
  import spi_slave_pkg::*;
#(
  parameter int N = 8,
  parameter logic [N-1:0] IDLE_WORD = IDLE_WORD_DEFAULT[N-1:0]
) (
  input  logic         clk_c,
  input  logic         reset_r,
  input  logic         sclk_i,
  input  logic         cs_n_i,
  input  logic         mosi_i,
  output logic         miso_o,
  output logic         miso_oe_o,
  input  logic [N-1:0] tx_data_i,
  input  logic         tx_valid_i,
  output logic         tx_ready_o,
  output logic [N-1:0] rx_data_o,
  output logic         rx_valid_o,
  output logic         busy_o,
  output logic         tx_underrun_o
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic sclk_lvl;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_lvl;
  logic cs_rise;
  logic cs_fall;
  logic mosi_lvl;
  logic mosi_rise;
  logic mosi_fall;
  logic unused_sync;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [N-2:0]  rx_sr;
  logic [N-1:0]  rx_next;
  logic [N-1:0]  tx_sr;
  logic [N-1:0]  buf_data;
  logic [N-1:0]  load_word;
  logic          buf_full;
  logic          load;
  logic          write;
  logic          rx_shift;

  spi_sync_edge #(.RST_VAL(SCLK_IDLE)) u_sclk (
    .clk_c  (clk_c),
    .reset_r(reset_r),
    .d      (sclk_i),
    .level  (sclk_lvl),
    .rise   (sclk_rise),
    .fall   (sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(CS_N_IDLE)) u_cs (
    .clk_c  (clk_c),
    .reset_r(reset_r),
    .d      (cs_n_i),
    .level  (cs_lvl),
    .rise   (cs_rise),
    .fall   (cs_fall)
  );

  spi_sync_edge #(.RST_VAL(MOSI_IDLE)) u_mosi (
    .clk_c  (clk_c),
    .reset_r(reset_r),
    .d      (mosi_i),
    .level  (mosi_lvl),
    .rise   (mosi_rise),
    .fall   (mosi_fall)
  );

  assign unused_sync = sclk_lvl ^ cs_rise ^ mosi_rise ^ mosi_fall;

  assign rx_next   = {rx_sr, mosi_lvl};
  assign load_word = buf_full ? buf_data : IDLE_WORD;
  assign write     = tx_valid_i & ~buf_full;
  assign rx_shift  = (state == ACTIVE) & ~cs_lvl & sclk_rise;
  assign load      = (state == IDLE)
                   ? cs_fall
                   : (~cs_lvl & sclk_fall & (bit_cnt == '0));

  // Holding buffer: a load sees the pre-write state, no bypass
  always_ff @(posedge clk_c or posedge reset_r) begin
    if (reset_r) begin
      buf_full      <= 1'b0;
      buf_data      <= '0;
      tx_underrun_o <= 1'b0;
    end else begin
      buf_full      <= write | (buf_full & ~load);
      tx_underrun_o <= load & ~buf_full;
      if (write) buf_data <= tx_data_i;
    end
  end

  // Frame control, bit counting and transmit shifting
  always_ff @(posedge clk_c or posedge reset_r) begin
    if (reset_r) begin
      state   <= IDLE;
      bit_cnt <= '0;
      tx_sr   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= ACTIVE;
            bit_cnt <= '0;
            tx_sr   <= load_word;
          end
        end
        ACTIVE: begin
          if (cs_lvl) begin
            state   <= IDLE;
            bit_cnt <= '0;
            tx_sr   <= '0;
          end else begin
            if (sclk_rise) begin
              if (bit_cnt == LAST) bit_cnt <= '0;
              else bit_cnt <= bit_cnt + 1'b1;
            end
            if (sclk_fall) begin
              if (bit_cnt == '0) tx_sr <= load_word;
              else tx_sr <= tx_sr << 1;
            end
          end
        end
      endcase
    end
  end

  // Receive shifting and word completion pulse
  always_ff @(posedge clk_c or posedge reset_r) begin
    if (reset_r) begin
      rx_sr      <= '0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      if (rx_shift) begin
        rx_sr <= rx_next[N-2:0];
        if (bit_cnt == LAST) begin
          rx_data_o  <= rx_next;
          rx_valid_o <= 1'b1;
        end
      end
    end
  end

  assign busy_o     = (state == ACTIVE);
  assign miso_oe_o  = busy_o;
  assign miso_o     = tx_sr[N-1] & miso_oe_o;
  assign tx_ready_o = ~buf_full;

endmodule

// File: tb/tb_spi_slave_shiftreg.sv
// Bench for spi_slave_shiftreg: a mode-0 master drives frames,
// expected words come from a per-word model of the protocol.
module tb_spi_slave_shiftreg;

  logic       clk_c = 1'b0;
  logic       reset_r;
  logic       sclk_i;
  logic       cs_n_i;
  logic       mosi_i;
  logic       miso_o;
  logic       miso_oe_o;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       busy_o;
  logic       tx_underrun_o;

  spi_slave_shiftreg dut (
    .clk_c        (clk_c),
    .reset_r      (reset_r),
    .sclk_i       (sclk_i),
    .cs_n_i       (cs_n_i),
    .mosi_i       (mosi_i),
    .miso_o       (miso_o),
    .miso_oe_o    (miso_oe_o),
    .tx_data_i    (tx_data_i),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .busy_o       (busy_o),
    .tx_underrun_o(tx_underrun_o)
  );

  always #5 clk_c = ~clk_c;

  int total = 0;
  int bad = 0;

  logic [7:0] rxq[$];
  int urun_cnt = 0;
  int dbl = 0;
  logic prev_v = 1'b0;

  always @(negedge clk_c) begin
    if (rx_valid_o) rxq.push_back(rx_data_o);
    if (rx_valid_o && prev_v) dbl++;
    prev_v = rx_valid_o;
    if (tx_underrun_o) urun_cnt++;
  end

  int         f_n;
  int         f_h;
  logic [7:0] f_mosi[4];
  logic [7:0] f_tx[4];
  logic [7:0] f_got[4];
  bit         f_wr[4];
  bit         f_coinc;
  logic [7:0] f_cdata;
  logic [7:0] e_rx[4];
  logic [7:0] e_miso[4];
  int         e_urun;

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] tx;
    bit         wr;
    int         h;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
    int         exp_urun;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic write_word(input logic [7:0] d);
    chk("tx_ready_before_write", 32'(tx_ready_o), 1);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    @(negedge clk_c);
    tx_valid_i = 1'b0;
  endtask

  task automatic frame();
    if (f_wr[0] && !f_coinc) write_word(f_tx[0]);
    @(negedge clk_c);
    cs_n_i = 1'b0;
    @(negedge clk_c);
    @(negedge clk_c);
    chk("busy_before_load", 32'(busy_o), 0);
    chk("tx_ready_before_load", 32'(tx_ready_o),
        f_wr[0] ? 0 : 1);
    if (f_coinc) begin
      tx_data_i  = f_cdata;
      tx_valid_i = 1'b1;
    end
    @(negedge clk_c);
    tx_valid_i = 1'b0;
    chk("busy_after_cs", 32'(busy_o), 1);
    chk("oe_after_cs", 32'(miso_oe_o), 1);
    chk("tx_ready_after_cs", 32'(tx_ready_o),
        f_coinc ? 0 : 1);
    chk("urun_at_cs", 32'(tx_underrun_o),
        (f_coinc || !f_wr[0]) ? 1 : 0);
    repeat (f_h - 3) @(negedge clk_c);
    for (int w = 0; w < f_n; w++) begin
      for (int b = 7; b >= 0; b--) begin
        mosi_i = f_mosi[w][b];
        repeat (f_h) @(negedge clk_c);
        f_got[w][b] = miso_o;
        sclk_i = 1'b1;
        if (b == 4 && w + 1 < f_n && f_wr[w+1]) begin
          write_word(f_tx[w+1]);
          repeat (f_h - 1) @(negedge clk_c);
        end else begin
          repeat (f_h) @(negedge clk_c);
        end
        if (!(w == f_n - 1 && b == 0)) sclk_i = 1'b0;
      end
    end
    cs_n_i = 1'b1;
    repeat (4) @(negedge clk_c);
    sclk_i = 1'b0;
    mosi_i = 1'b0;
    repeat (6) @(negedge clk_c);
  endtask

  task automatic run_frame(input string tag);
    int u0;
    rxq.delete();
    u0 = urun_cnt;
    frame();
    chk({tag, "_rx_count"}, 32'(rxq.size()), 32'(f_n));
    for (int w = 0; w < f_n; w++) begin
      if (w < rxq.size())
        chk({tag, "_rx_data"}, 32'(rxq[w]), 32'(e_rx[w]));
      chk({tag, "_miso_word"}, 32'(f_got[w]), 32'(e_miso[w]));
    end
    chk({tag, "_underruns"}, 32'(urun_cnt - u0), 32'(e_urun));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_miso"}, 32'(miso_o), 0);
    chk({tag, "_miso_oe"}, 32'(miso_oe_o), 0);
    chk({tag, "_tx_ready"}, 32'(tx_ready_o), 1);
    chk({tag, "_rx_valid"}, 32'(rx_valid_o), 0);
    chk({tag, "_rx_data"}, 32'(rx_data_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_underrun"}, 32'(tx_underrun_o), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{8'h3C, 8'hA5, 1'b1, 8, 8'h3C, 8'hA5, 0};
    tbl[1] = '{8'hC9, 8'h00, 1'b0, 5, 8'hC9, 8'hFF, 1};
    tbl[2] = '{8'hFF, 8'h00, 1'b1, 4, 8'hFF, 8'h00, 0};
    tbl[3] = '{8'h80, 8'h01, 1'b1, 6, 8'h80, 8'h01, 0};
    tbl[4] = '{8'h01, 8'h80, 1'b1, 4, 8'h01, 8'h80, 0};

    reset_r    = 1'b1;
    sclk_i     = 1'b0;
    cs_n_i     = 1'b1;
    mosi_i     = 1'b0;
    tx_data_i  = '0;
    tx_valid_i = 1'b0;
    f_coinc    = 1'b0;
    f_cdata    = '0;
    repeat (3) @(negedge clk_c);
    reset_r = 1'b0;
    repeat (3) @(negedge clk_c);
    chk_reset_vals("reset");

    foreach (tbl[i]) begin
      f_n       = 1;
      f_h       = tbl[i].h;
      f_coinc   = 1'b0;
      f_mosi[0] = tbl[i].mosi;
      f_tx[0]   = tbl[i].tx;
      f_wr[0]   = tbl[i].wr;
      e_rx[0]   = tbl[i].exp_rx;
      e_miso[0] = tbl[i].exp_miso;
      e_urun    = tbl[i].exp_urun;
      run_frame("table");
    end

    f_n = 2; f_h = 6; f_coinc = 1'b0;
    f_mosi[0] = 8'h12; f_mosi[1] = 8'h34;
    f_tx[0] = 8'h81; f_tx[1] = 8'h7E;
    f_wr[0] = 1'b1; f_wr[1] = 1'b1;
    e_rx[0] = 8'h12; e_rx[1] = 8'h34;
    e_miso[0] = 8'h81; e_miso[1] = 8'h7E;
    e_urun = 0;
    run_frame("two_word");

    f_n = 2; f_h = 5; f_coinc = 1'b1; f_cdata = 8'h96;
    f_mosi[0] = 8'hC3; f_mosi[1] = 8'h3C;
    f_wr[0] = 1'b0; f_wr[1] = 1'b0;
    e_rx[0] = 8'hC3; e_rx[1] = 8'h3C;
    e_miso[0] = 8'hFF; e_miso[1] = 8'h96;
    e_urun = 1;
    run_frame("write_at_load");
    f_coinc = 1'b0;

    rxq.delete();
    @(negedge clk_c);
    cs_n_i = 1'b0;
    repeat (6) @(negedge clk_c);
    for (int b = 0; b < 5; b++) begin
      mosi_i = 1'b1;
      repeat (6) @(negedge clk_c);
      sclk_i = 1'b1;
      repeat (6) @(negedge clk_c);
      if (b < 4) sclk_i = 1'b0;
    end
    cs_n_i = 1'b1;
    @(negedge clk_c);
    @(negedge clk_c);
    chk("abort_busy_held", 32'(busy_o), 1);
    @(negedge clk_c);
    chk("abort_busy_fall", 32'(busy_o), 0);
    chk("abort_oe_fall", 32'(miso_oe_o), 0);
    sclk_i = 1'b0;
    mosi_i = 1'b0;
    repeat (10) @(negedge clk_c);
    chk("abort_no_pulse", 32'(rxq.size()), 0);

    f_n = 1; f_h = 7;
    f_mosi[0] = 8'h55; f_tx[0] = 8'h0F; f_wr[0] = 1'b1;
    e_rx[0] = 8'h55; e_miso[0] = 8'h0F; e_urun = 0;
    run_frame("after_abort");

    write_word(8'h5A);
    @(negedge clk_c);
    cs_n_i = 1'b0;
    repeat (6) @(negedge clk_c);
    for (int b = 0; b < 3; b++) begin
      mosi_i = b[0];
      repeat (6) @(negedge clk_c);
      sclk_i = 1'b1;
      repeat (6) @(negedge clk_c);
      if (b < 2) sclk_i = 1'b0;
    end
    write_word(8'hC6);
    chk("midframe_buf_full", 32'(tx_ready_o), 0);
    chk("midframe_busy", 32'(busy_o), 1);
    #2;
    reset_r = 1'b1;
    #1;
    chk_reset_vals("midreset");
    sclk_i = 1'b0;
    cs_n_i = 1'b1;
    mosi_i = 1'b0;
    repeat (3) @(negedge clk_c);
    reset_r = 1'b0;
    repeat (3) @(negedge clk_c);
    chk_reset_vals("post_reset");

    for (int fr = 0; fr < 6; fr++) begin
      f_n = int'($urandom_range(1, 3));
      f_h = int'($urandom_range(4, 9));
      f_coinc = 1'b0;
      e_urun = 0;
      for (int w = 0; w < 4; w++) begin
        f_mosi[w] = 8'($urandom);
        f_tx[w]   = 8'($urandom);
        f_wr[w]   = 1'($urandom_range(0, 1));
        e_rx[w]   = f_mosi[w];
        e_miso[w] = f_wr[w] ? f_tx[w] : 8'hFF;
        if (w < f_n && !f_wr[w]) e_urun++;
      end
      run_frame("random");
    end

    chk("rx_valid_single", 32'(dbl), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
